// File: rtl/bullet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bullet_scheduler
// Purpose  : Bullet pool controller. Turns fire presses into one-hot launch
//            pulses on a shared launch bus, tracks occupied slots, enforces a
//            frame-based cooldown between shots, and once per frame walks the
//            active slots onto the single draw path with a req/ack handshake.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            fire, frame_tick   - fire button level, once-per-frame pulse
//            ship_x/y, dir_x/y  - ship position/heading captured at launch
//            done               - per-slot release pulse
//            draw_ack           - plotter accepted draw_sel
//            load               - one-hot one-cycle launch pulse
//            start_x/y/dx/dy    - launch bus, valid while load != 0
//            active             - slot-occupied flags
//            draw_req, draw_sel - draw request and slot index
//            frame_overrun      - sticky, frame_tick seen mid-scan
// Config   : BULLET_AUTOFIRE_EN - when defined, the fire level (not its
//            rising edge) triggers shots, giving autofire while held.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_scheduler #(
  parameter int NUM_BULLETS = 8,
  parameter int COOLDOWN    = 12,
  parameter int SEL_W       = $clog2(NUM_BULLETS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic                   frame_tick,
  input  logic [7:0]             ship_x,
  input  logic [6:0]             ship_y,
  input  logic [1:0]             dir_x,
  input  logic [1:0]             dir_y,
  input  logic [NUM_BULLETS-1:0] done,
  input  logic                   draw_ack,
  output logic [NUM_BULLETS-1:0] load,
  output logic [7:0]             start_x,
  output logic [6:0]             start_y,
  output logic [1:0]             start_dx,
  output logic [1:0]             start_dy,
  output logic [NUM_BULLETS-1:0] active,
  output logic                   draw_req,
  output logic [SEL_W-1:0]       draw_sel,
  output logic                   frame_overrun
);

  localparam int                   CD_W      = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0]      CD_LOAD   = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]      CD_ONE    = CD_W'(1);
  localparam logic [SEL_W-1:0]     LAST_SLOT = SEL_W'(NUM_BULLETS - 1);
  localparam logic [SEL_W-1:0]     PTR_ONE   = SEL_W'(1);
  localparam logic [NUM_BULLETS-1:0] ACT_ONE = NUM_BULLETS'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;

  // --------------------------------------------------------------------------
  // Shot allocation
  // --------------------------------------------------------------------------
  logic                   fire_q;
  logic [CD_W-1:0]        cooldown;
  logic                   trigger;
  logic                   accept;
  logic [NUM_BULLETS-1:0] free_onehot;

`ifdef BULLET_AUTOFIRE_EN
  assign trigger = fire;
`else
  assign trigger = fire & ~fire_q;
`endif

  // Isolates the lowest clear bit of active; zero when every slot is taken.
  // Uses the current active value, so a slot released this cycle is not yet
  // eligible.
  assign free_onehot = ~active & (active + ACT_ONE);
  assign accept      = trigger && (cooldown == '0) && (free_onehot != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q   <= 1'b0;
      cooldown <= '0;
      load     <= '0;
      active   <= '0;
      start_x  <= '0;
      start_y  <= '0;
      start_dx <= '0;
      start_dy <= '0;
    end else begin
      fire_q <= fire;
      load   <= accept ? free_onehot : '0;
      // A release and an allocation in the same cycle both land; they can
      // never target the same slot because only a free slot is allocated.
      active <= (active & ~done) | (accept ? free_onehot : '0);
      if (accept) begin
        cooldown <= CD_LOAD;
        start_x  <= ship_x;
        start_y  <= ship_y;
        start_dx <= dir_x;
        start_dy <= dir_y;
      end else if (frame_tick && (cooldown != '0)) begin
        cooldown <= cooldown - CD_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Draw scheduler FSM
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nx;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      frame_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      // A new frame while still walking the pool means the scan budget was
      // exceeded; the tick itself is dropped.
      if (frame_tick && (state != S_IDLE)) begin
        frame_overrun <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          ptr_nx   = '0;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (active[ptr]) begin
          state_nx = S_REQ;
        end else if (ptr == LAST_SLOT) begin
          state_nx = S_IDLE;
        end else begin
          ptr_nx = ptr + PTR_ONE;
        end
      end
      S_REQ: begin
        // The handshake completes even if the slot was released meanwhile.
        if (draw_ack) begin
          if (ptr == LAST_SLOT) begin
            state_nx = S_IDLE;
          end else begin
            ptr_nx   = ptr + PTR_ONE;
            state_nx = S_SCAN;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    draw_req = (state == S_REQ);
    draw_sel = (state == S_REQ) ? ptr : '0;
  end

endmodule
`default_nettype wire
